nine_segment_frame_sequencer: RTL and testbench

NINE_SEGMENT_FRAME_SEQUENCER -- requirements
Module: nine_segment_frame_sequencer

---
 rtl/nine_segment_pkg.sv | 13 +
 rtl/nine_segment_frame_sequencer_dwell_timer.sv | 38 +++
 rtl/nine_segment_frame_sequencer.sv | 144 ++++++++++++++
 tb/tb_nine_segment_frame_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nine_segment_pkg.sv
// rtl/nine_segment_pkg.sv - shared types for the nine-segment frame sequencer
package nine_segment_pkg;

  typedef logic [8:0] segment_t;

  localparam segment_t SEG_BLANK = 9'h000;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } seq_state_t;

endpackage

// File: rtl/nine_segment_frame_sequencer_dwell_timer.sv
// rtl/nine_segment_frame_sequencer_dwell_timer.sv - per-frame dwell countdown
// Expires in the last cycle of a frame; a zero dwell value behaves as one cycle.
module dwell_timer #(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic               clr_i,
  input  logic               run_i,
  input  logic [DWELL_W-1:0] value_i,
  output logic               expire_o
);

  logic [DWELL_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = (value_i == '0) ? '0 : value_i - DWELL_W'(1);
    end else if (run_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - DWELL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = run_i && (cnt_q == '0);

endmodule

// File: rtl/nine_segment_frame_sequencer.sv
// rtl/nine_segment_frame_sequencer.sv - frame buffer with timed playback to a nine-segment display
// Frames are loaded in IDLE and replayed cyclically in PLAY, each shown for a sampled dwell.
module nine_segment_frame_sequencer
  import nine_segment_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int DWELL_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [8:0]                 wr_data,
  input  logic                       clear,
  input  logic                       start,
  input  logic                       stop,
  input  logic [DWELL_W-1:0]         dwell,
  output logic [8:0]                 segments,
  output logic [$clog2(DEPTH)-1:0]   frame_idx,
  output logic                       busy,
  output logic                       advance
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  seq_state_t    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  segment_t      seg_q, seg_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          adv_q, adv_d;

  segment_t      mem_q [DEPTH];

  logic          wr_fire;
  logic          rd_last;
  logic [AW-1:0] rd_next;
  logic          tmr_load;
  logic          tmr_clr;
  logic          tmr_expire;

  // Gated by reset so the write handshake stays closed while reset is held.
  assign wr_ready = !reset && (state_q == IDLE) && (count_q < CW'(DEPTH)) && !clear;
  assign wr_fire  = wr_valid && wr_ready;

  assign rd_last = ({1'b0, rd_ptr_q} == (count_q - CW'(1)));
  assign rd_next = rd_last ? '0 : rd_ptr_q + AW'(1);

  dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_dwell_timer (
    .clk      (clk),
    .rst      (reset),
    .load_i   (tmr_load),
    .clr_i    (tmr_clr),
    .run_i    (state_q == PLAY),
    .value_i  (dwell),
    .expire_o (tmr_expire)
  );

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    seg_d    = seg_q;
    idx_d    = idx_q;
    adv_d    = 1'b0;
    tmr_load = 1'b0;
    tmr_clr  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (clear) begin
          count_d  = '0;
          wr_ptr_d = '0;
        end else if (wr_fire) begin
          count_d  = count_q + CW'(1);
          wr_ptr_d = wr_ptr_q + AW'(1);
        end
        // Stop wins over start; a simultaneous clear also blocks entry so PLAY never sees an empty buffer.
        if (start && !stop && !clear && (count_q != '0)) begin
          state_d  = PLAY;
          rd_ptr_d = '0;
          seg_d    = mem_q[0];
          idx_d    = '0;
          tmr_load = 1'b1;
        end
      end
      PLAY: begin
        if (stop) begin
          state_d  = IDLE;
          rd_ptr_d = '0;
          seg_d    = SEG_BLANK;
          idx_d    = '0;
          tmr_clr  = 1'b1;
        end else if (tmr_expire) begin
          rd_ptr_d = rd_next;
          seg_d    = mem_q[rd_next];
          idx_d    = rd_next;
          adv_d    = 1'b1;
          tmr_load = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      seg_q    <= SEG_BLANK;
      idx_q    <= '0;
      adv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      seg_q    <= seg_d;
      idx_q    <= idx_d;
      adv_q    <= adv_d;
    end
  end

  assign segments  = seg_q;
  assign frame_idx = idx_q;
  assign busy      = (state_q == PLAY);
  assign advance   = adv_q;

endmodule

// File: tb/tb_nine_segment_frame_sequencer.sv
// tb/tb_nine_segment_frame_sequencer.sv - self-checking bench for nine_segment_frame_sequencer
module tb_nine_segment_frame_sequencer;

  localparam int DEPTH   = 4;
  localparam int DWELL_W = 16;

  logic               clk;
  logic               reset;
  logic               wr_valid;
  logic               wr_ready;
  logic [8:0]         wr_data;
  logic               clear;
  logic               start;
  logic               stop;
  logic [DWELL_W-1:0] dwell;
  logic [8:0]         segments;
  logic [1:0]         frame_idx;
  logic               busy;
  logic               advance;

  nine_segment_frame_sequencer #(
    .DEPTH   (DEPTH),
    .DWELL_W (DWELL_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .clear     (clear),
    .start     (start),
    .stop      (stop),
    .dwell     (dwell),
    .segments  (segments),
    .frame_idx (frame_idx),
    .busy      (busy),
    .advance   (advance)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Playback is described as a closed form of cycles elapsed since start:
  // frame = floor((k-1)/dwell) mod frames, with advance on every later multiple of dwell.
  logic [8:0] m_buf [DEPTH];
  int         m_count   = 0;
  bit         m_playing = 1'b0;
  int         m_k       = 0;
  int         m_d       = 1;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_playing = 1'b0;
      m_count   = 0;
      m_k       = 0;
    end else if (!m_playing) begin
      int old_count;
      old_count = m_count;
      if (clear) begin
        m_count = 0;
      end else if (wr_valid && (m_count < DEPTH)) begin
        m_buf[m_count] = wr_data;
        m_count++;
      end
      if (start && !stop && !clear && (old_count > 0)) begin
        m_playing = 1'b1;
        m_k       = 1;
        m_d       = (dwell == 0) ? 1 : int'(dwell);
      end
    end else begin
      if (stop) m_playing = 1'b0;
      else      m_k++;
    end
  end

  logic [8:0] e_seg;
  int         e_idx;
  logic       e_adv, e_busy, e_rdy;

  always @(negedge clk) begin
    if (check_en) begin
      if (m_playing) begin
        e_idx  = ((m_k - 1) / m_d) % m_count;
        e_seg  = m_buf[e_idx];
        e_adv  = (m_k > 1) && (((m_k - 1) % m_d) == 0);
        e_busy = 1'b1;
        e_rdy  = 1'b0;
      end else begin
        e_idx  = 0;
        e_seg  = 9'h000;
        e_adv  = 1'b0;
        e_busy = 1'b0;
        e_rdy  = !reset && (m_count < DEPTH) && !clear;
      end
      chk("model segments",  32'(segments),  32'(e_seg));
      chk("model frame_idx", 32'(frame_idx), 32'(e_idx));
      chk("model advance",   32'(advance),   32'(e_adv));
      chk("model busy",      32'(busy),      32'(e_busy));
      chk("model wr_ready",  32'(wr_ready),  32'(e_rdy));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [8:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    cyc();
    wr_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  initial begin
    #100000;
    fails++;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    wr_valid = 1'b0;
    wr_data  = '0;
    clear    = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    dwell    = 16'd1;

    cyc();
    cyc();
    chk("reset wr_ready", 32'(wr_ready), 32'd0);
    chk("reset segments", 32'(segments), 32'd0);
    chk("reset busy",     32'(busy),     32'd0);
    check_en = 1'b1;
    reset = 1'b0;
    #1;
    chk("post reset wr_ready", 32'(wr_ready), 32'd1);

    // Fill to capacity; the fifth write must bounce.
    wr(9'h010);
    wr(9'h1FF);
    wr(9'h000);
    chk("3 frames wr_ready", 32'(wr_ready), 32'd1);
    wr(9'h0AA);
    chk("full wr_ready", 32'(wr_ready), 32'd0);
    wr(9'h155);
    chk("overflow wr_ready", 32'(wr_ready), 32'd0);

    dwell = 16'd1;
    pulse_start();
    chk("full play frame0", 32'(segments), 32'h010);
    repeat (5) cyc();
    pulse_stop();

    clear = 1'b1;
    cyc();
    clear = 1'b0;
    #1;
    chk("clear wr_ready", 32'(wr_ready), 32'd1);

    pulse_start();
    chk("empty start busy", 32'(busy),     32'd0);
    chk("empty start seg",  32'(segments), 32'd0);

    // Two frames, dwell 3: frame 0 for cycles 1-3, frame 1 for 4-6, frame 0 again at 7.
    wr(9'h010);
    wr(9'h145);
    dwell = 16'd3;
    pulse_start();
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) cyc();
      chk($sformatf("dwell3 seg c%0d", c), 32'(segments), ((c <= 3) || (c == 7)) ? 32'h010 : 32'h145);
      chk($sformatf("dwell3 adv c%0d", c), 32'(advance),  ((c == 4) || (c == 7)) ? 32'd1 : 32'd0);
    end

    wr_valid = 1'b1;
    wr_data  = 9'h1FF;
    clear    = 1'b1;
    cyc();
    wr_valid = 1'b0;
    clear    = 1'b0;
    pulse_stop();
    chk("stop seg",  32'(segments), 32'd0);
    chk("stop busy", 32'(busy),     32'd0);

    pulse_start();
    chk("restart seg", 32'(segments),  32'h010);
    chk("restart idx", 32'(frame_idx), 32'd0);
    repeat (6) cyc();
    chk("restart wrap seg", 32'(segments), 32'h010);
    chk("restart wrap adv", 32'(advance),  32'd1);
    pulse_stop();

    dwell = 16'd0;
    pulse_start();
    for (int c = 2; c <= 5; c++) begin
      cyc();
      chk($sformatf("dwell0 seg c%0d", c), 32'(segments), (c % 2 == 0) ? 32'h145 : 32'h010);
      chk($sformatf("dwell0 adv c%0d", c), 32'(advance),  32'd1);
    end
    pulse_stop();
    dwell = 16'd3;

    start = 1'b1;
    stop  = 1'b1;
    cyc();
    start = 1'b0;
    stop  = 1'b0;
    chk("start+stop busy", 32'(busy), 32'd0);

    // Reset lands between edges during a frame.
    pulse_start();
    cyc();
    #2;
    reset = 1'b1;
    #1;
    chk("async reset seg",      32'(segments), 32'd0);
    chk("async reset busy",     32'(busy),     32'd0);
    chk("async reset wr_ready", 32'(wr_ready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("after reset wr_ready", 32'(wr_ready), 32'd1);
    pulse_start();
    chk("after reset empty busy", 32'(busy), 32'd0);
    wr(9'h001);
    wr(9'h002);
    wr(9'h003);
    chk("after reset 3 writes wr_ready", 32'(wr_ready), 32'd1);
    wr(9'h004);
    chk("after reset full wr_ready", 32'(wr_ready), 32'd0);
    cyc();

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
